// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter that owns the shared register x.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DATA_W   = 1;
    localparam int DEF_MAX_HOLD = 8;

    // Modular add used for both the scan order and the pointer advance.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/shared_x_if.sv
// Holds the shared register x; the arbiter is its only writer.
interface shared_x_if #(
    parameter int DATA_W = 1
);
    logic [DATA_W-1:0] x;

    modport owner (output x);
    modport user  (input  x);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request bit at or after ptr, modulo N_REQ.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int cand_s;

    // Walk the request vector starting at ptr and keep the first hit.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        cand_s = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = wrap_add(int'(ptr), i, N_REQ);
            if (req[cand_s] && !found) begin
                found = 1'b1;
                idx   = IDX_W'(cand_s);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/intf_rr_arbiter.sv
// Round-robin arbiter granting exclusive write access to a shared register x,
// with a bounded hold time and a mandatory one-cycle gap between grants.
module intf_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_wdata,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [$clog2(N_REQ)-1:0]  o_gnt_idx,
    output logic [DATA_W-1:0]         o_x,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_state_e        state_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  gnt_idx_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [N_REQ-1:0]  gnt_r;
    logic              busy_r;
    logic              timeout_r;

    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_found_s;
    logic              hold_req_s;
    logic [DATA_W-1:0] wslice_s;
    logic [IDX_W-1:0]  next_ptr_s;
    logic              last_cycle_s;

    shared_x_if #(.DATA_W(DATA_W)) x_if ();

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Decode the granted requester's hold bit, its data slice and the post-release pointer.
    always_comb begin
        hold_req_s   = i_req[gnt_idx_r];
        wslice_s     = i_wdata[int'(gnt_idx_r) * DATA_W +: DATA_W];
        next_ptr_s   = IDX_W'(wrap_add(int'(gnt_idx_r), 1, N_REQ));
        last_cycle_s = (cnt_r == CNT_W'(MAX_HOLD - 1));
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            gnt_idx_r <= '0;
            cnt_r     <= '0;
            gnt_r     <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            x_if.x    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    timeout_r <= 1'b0;
                    cnt_r     <= '0;
                    if (pick_found_s) begin
                        state_r   <= BUSY;
                        gnt_r     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                        gnt_idx_r <= pick_idx_s;
                        busy_r    <= 1'b1;
                    end else begin
                        gnt_r     <= '0;
                        gnt_idx_r <= '0;
                        busy_r    <= 1'b0;
                    end
                end
                BUSY: begin
                    // A held request on the last allowed cycle still writes, then is forced off.
                    if (hold_req_s && !last_cycle_s) begin
                        x_if.x <= wslice_s;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end else begin
                        if (hold_req_s) begin
                            x_if.x <= wslice_s;
                        end
                        state_r   <= GAP;
                        ptr_r     <= next_ptr_s;
                        gnt_r     <= '0;
                        gnt_idx_r <= '0;
                        busy_r    <= 1'b0;
                        cnt_r     <= '0;
                        timeout_r <= hold_req_s;
                    end
                end
                GAP: begin
                    state_r   <= IDLE;
                    timeout_r <= 1'b0;
                    gnt_r     <= '0;
                    gnt_idx_r <= '0;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    timeout_r <= 1'b0;
                    gnt_r     <= '0;
                    gnt_idx_r <= '0;
                    busy_r    <= 1'b0;
                    cnt_r     <= '0;
                end
            endcase
        end
    end

    assign o_gnt     = gnt_r;
    assign o_gnt_idx = gnt_idx_r;
    assign o_x       = x_if.x;
    assign o_busy    = busy_r;
    assign o_timeout = timeout_r;

endmodule
